// File: rtl/lsu_mem_ctrl.sv
// RV32I load/store unit front-end for a word-wide data memory with async read.
// Handles lane extraction/extension for loads and read-modify-write for sub-word stores.
module lsu_mem_ctrl #(
    parameter int DEPTH = 2048,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_i,
    input  logic          req_valid_i,
    output logic          req_ready_o,
    input  logic          req_we_i,
    input  logic [2:0]    req_funct3_i,
    input  logic [31:0]   req_addr_i,
    input  logic [31:0]   req_wdata_i,
    output logic          rsp_valid_o,
    output logic [31:0]   rsp_rdata_o,
    output logic          rsp_err_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [31:0]   mem_wdata_o,
    output logic          mem_we_o,
    input  logic [31:0]   mem_rdata_i
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] LOAD   = 3'd1;
    localparam logic [2:0] RMW_RD = 3'd2;
    localparam logic [2:0] WRITE  = 3'd3;
    localparam logic [2:0] RESP   = 3'd4;

    logic [2:0]    state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [2:0]    funct3_q, funct3_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          err_q, err_d;

    logic          reqErr;
    logic [7:0]    loadByte;
    logic [15:0]   loadHalf;
    logic [31:0]   loadData;
    logic [31:0]   mergedData;

    // Range check uses the full 32-bit address, not the truncated memory address.
    always_comb begin
        reqErr = 1'b0;
        if (req_we_i) begin
            if (req_funct3_i > 3'd2) reqErr = 1'b1;
        end else begin
            if (req_funct3_i == 3'b011 || req_funct3_i[2:1] == 2'b11) reqErr = 1'b1;
        end
        if (req_funct3_i[1:0] == 2'b01 && req_addr_i[0]) reqErr = 1'b1;
        if (req_funct3_i[1:0] == 2'b10 && req_addr_i[1:0] != 2'b00) reqErr = 1'b1;
        if (req_addr_i >= 32'(DEPTH)) reqErr = 1'b1;
    end

    always_comb begin
        loadByte = mem_rdata_i[{addr_q[1:0], 3'b000} +: 8];
        loadHalf = addr_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
        case (funct3_q)
            3'b000:  loadData = {{24{loadByte[7]}}, loadByte};
            3'b001:  loadData = {{16{loadHalf[15]}}, loadHalf};
            3'b010:  loadData = mem_rdata_i;
            3'b100:  loadData = {24'd0, loadByte};
            3'b101:  loadData = {16'd0, loadHalf};
            default: loadData = 32'd0;
        endcase
        mergedData = mem_rdata_i;
        if (funct3_q[0]) begin
            mergedData[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
        end else begin
            mergedData[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
        end
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        funct3_d = funct3_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    addr_d   = req_addr_i[AW-1:0];
                    funct3_d = req_funct3_i;
                    wdata_d  = req_wdata_i;
                    rdata_d  = 32'd0;
                    err_d    = reqErr;
                    if (reqErr)                          state_d = RESP;
                    else if (!req_we_i)                  state_d = LOAD;
                    else if (req_funct3_i[1:0] == 2'b10) state_d = WRITE;
                    else                                 state_d = RMW_RD;
                end
            end
            LOAD: begin
                rdata_d = loadData;
                state_d = RESP;
            end
            RMW_RD: begin
                wdata_d = mergedData;
                state_d = WRITE;
            end
            WRITE:   state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            funct3_q <= 3'd0;
            wdata_q  <= 32'd0;
            rdata_q  <= 32'd0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            funct3_q <= funct3_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    assign req_ready_o = (state_q == IDLE);
    assign rsp_valid_o = (state_q == RESP);
    assign rsp_err_o   = rsp_valid_o & err_q;
    assign rsp_rdata_o = rdata_q;
    assign mem_we_o    = (state_q == WRITE);
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Self-checking bench for lsu_mem_ctrl: directed plan items plus randomized traffic
// checked against a byte-array reference model of the data memory.
module tb_lsu_mem_ctrl;

   localparam int DEPTH = 2048;
   localparam int AW = $clog2(DEPTH);

   logic clk = 1'b0;
   logic rst_i;
   logic req_valid_i;
   logic req_ready_o;
   logic req_we_i;
   logic [2:0] req_funct3_i;
   logic [31:0] req_addr_i;
   logic [31:0] req_wdata_i;
   logic rsp_valid_o;
   logic [31:0] rsp_rdata_o;
   logic rsp_err_o;
   logic [AW-1:0] mem_addr_o;
   logic [31:0] mem_wdata_o;
   logic mem_we_o;
   logic [31:0] mem_rdata_i;

   logic [7:0] refMem [DEPTH];
   logic [31:0] tbMem [DEPTH/4];
   logic memInit;

   int total = 0;
   int bad = 0;

   typedef struct packed {
      int cyc;
      logic [31:0] data;
      logic err;
   } exp_t;

   exp_t expQ[$];

   lsu_mem_ctrl #(.DEPTH(DEPTH)) dut (
      .clk(clk),
      .rst_i(rst_i),
      .req_valid_i(req_valid_i),
      .req_ready_o(req_ready_o),
      .req_we_i(req_we_i),
      .req_funct3_i(req_funct3_i),
      .req_addr_i(req_addr_i),
      .req_wdata_i(req_wdata_i),
      .rsp_valid_o(rsp_valid_o),
      .rsp_rdata_o(rsp_rdata_o),
      .rsp_err_o(rsp_err_o),
      .mem_addr_o(mem_addr_o),
      .mem_wdata_o(mem_wdata_o),
      .mem_we_o(mem_we_o),
      .mem_rdata_i(mem_rdata_i)
   );

   // Free-running clock, 10 time units per cycle.
   always #5 clk = ~clk;

   // Attached word memory: async read, full-word write on the rising edge.
   always @(posedge clk) begin
      if (memInit) begin
         for (int i = 0; i < DEPTH/4; i++)
            tbMem[i] <= {refMem[4*i+3], refMem[4*i+2], refMem[4*i+1], refMem[4*i]};
      end else if (mem_we_o) begin
         tbMem[mem_addr_o[AW-1:2]] <= mem_wdata_o;
      end
   end

   assign mem_rdata_i = tbMem[mem_addr_o[AW-1:2]];

   // Every comparison in the bench funnels through here.
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference model: access legality from the RV32I rules and the memory size.
   function automatic logic modelErr(input logic we, input logic [2:0] f3, input logic [31:0] addr);
      int sizeBytes;
      logic legal;
      legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
      if (!legal) return 1'b1;
      sizeBytes = 1 << f3[1:0];
      if ((addr % sizeBytes) != 0) return 1'b1;
      if (addr >= DEPTH) return 1'b1;
      return 1'b0;
   endfunction

   function automatic int modelLatency(input logic we, input logic [2:0] f3, input logic err);
      if (err) return 1;
      if (!we) return 2;
      if (f3 == 3'd2) return 2;
      return 3;
   endfunction

   function automatic logic [31:0] refWord(input logic [31:0] addr);
      int a;
      a = int'(addr) & ~3;
      return {refMem[a+3], refMem[a+2], refMem[a+1], refMem[a]};
   endfunction

   // Load value computed from individual bytes with integer sign handling.
   function automatic logic [31:0] modelLoad(input logic [2:0] f3, input logic [31:0] addr);
      int a;
      int v;
      a = int'(addr);
      case (f3)
         3'd0: begin v = int'(refMem[a]); if (v > 127) v = v - 256; return v; end
         3'd1: begin v = int'(refMem[a]) + 256 * int'(refMem[a+1]); if (v > 32767) v = v - 65536; return v; end
         3'd2: return refWord(addr);
         3'd4: return int'(refMem[a]);
         3'd5: return int'(refMem[a]) + 256 * int'(refMem[a+1]);
         default: return 32'd0;
      endcase
   endfunction

   function automatic void modelStore(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd);
      int a;
      int n;
      logic [31:0] d;
      a = int'(addr);
      n = 1 << f3[1:0];
      d = wd;
      for (int i = 0; i < n; i++) begin
         refMem[a+i] = d[7:0];
         d = d >> 8;
      end
   endfunction

   // One complete request/response transaction, checked against the model.
   task automatic applyStimulus(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wd, output logic [31:0] gotData);
      logic expErr;
      logic [31:0] expData;
      int lat;
      int cyc;
      int weCnt;
      int weCyc;
      expErr = modelErr(we, f3, addr);
      expData = (!we && !expErr) ? modelLoad(f3, addr) : 32'd0;
      lat = modelLatency(we, f3, expErr);
      @(negedge clk);
      checkOutput("ready_idle", 32'(req_ready_o), 32'd1);
      req_valid_i = 1'b1;
      req_we_i = we;
      req_funct3_i = f3;
      req_addr_i = addr;
      req_wdata_i = wd;
      @(negedge clk);
      req_valid_i = 1'b0;
      req_addr_i = $urandom;
      cyc = 1;
      weCnt = 0;
      weCyc = 0;
      while (cyc <= 8 && !rsp_valid_o) begin
         if (mem_we_o) begin
            weCnt++;
            weCyc = cyc;
         end
         @(negedge clk);
         cyc++;
      end
      if (cyc > 8) cyc = 99;
      if (mem_we_o) weCnt++;
      checkOutput("latency", 32'(cyc), 32'(lat));
      checkOutput("rsp_err", 32'(rsp_err_o), 32'(expErr));
      checkOutput("rsp_rdata", rsp_rdata_o, expData);
      checkOutput("we_count", 32'(weCnt), (we && !expErr) ? 32'd1 : 32'd0);
      gotData = rsp_rdata_o;
      if (we && !expErr) begin
         checkOutput("we_cycle", 32'(weCyc), 32'(lat - 1));
         modelStore(f3, addr, wd);
         checkOutput("mem_word", tbMem[addr[AW-1:2]], refWord(addr));
      end
   endtask

   initial begin
      logic [31:0] d;
      int nextAccept;
      logic expRsp;
      logic hErr;
      logic [2:0] hF3;
      logic [31:0] hAddr;
      int hLat;
      logic rWe;
      logic [2:0] rF3;
      logic [31:0] rAddr;

      $display("[TB] starting lsu_mem_ctrl bench");
      req_valid_i = 1'b0;
      req_we_i = 1'b0;
      req_funct3_i = 3'd0;
      req_addr_i = 32'd0;
      req_wdata_i = 32'd0;
      for (int i = 0; i < DEPTH; i++) refMem[i] = 8'($urandom);
      refMem[16] = 8'hBB;
      refMem[17] = 8'hAA;
      refMem[18] = 8'h99;
      refMem[19] = 8'h88;
      memInit = 1'b1;
      rst_i = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      memInit = 1'b0;
      checkOutput("rst_ready", 32'(req_ready_o), 32'd1);
      checkOutput("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
      checkOutput("rst_rdata", rsp_rdata_o, 32'd0);
      checkOutput("rst_err", 32'(rsp_err_o), 32'd0);
      checkOutput("rst_we", 32'(mem_we_o), 32'd0);
      checkOutput("rst_addr", 32'(mem_addr_o), 32'd0);
      checkOutput("rst_wdata", mem_wdata_o, 32'd0);
      rst_i = 1'b0;

      // Directed loads on the known word at 0x10.
      applyStimulus(1'b0, 3'b000, 32'h11, 32'd0, d);
      checkOutput("lb_11", d, 32'hFFFFFFAA);
      applyStimulus(1'b0, 3'b100, 32'h13, 32'd0, d);
      checkOutput("lbu_13", d, 32'h00000088);
      applyStimulus(1'b0, 3'b001, 32'h12, 32'd0, d);
      checkOutput("lh_12", d, 32'hFFFF8899);
      applyStimulus(1'b0, 3'b010, 32'h10, 32'd0, d);
      checkOutput("lw_10", d, 32'h8899AABB);

      // Sub-word stores into the same word.
      applyStimulus(1'b1, 3'b000, 32'h12, 32'hFFFFFF55, d);
      checkOutput("sb_12_word", tbMem[4], 32'h8855AABB);
      applyStimulus(1'b1, 3'b001, 32'h10, 32'hABCD1234, d);
      checkOutput("sh_10_word", tbMem[4], 32'h88551234);
      applyStimulus(1'b0, 3'b101, 32'h12, 32'd0, d);
      checkOutput("lhu_12", d, 32'h00008855);

      // Store then load back-to-back.
      applyStimulus(1'b1, 3'b010, 32'h20, 32'hDEADBEEF, d);
      applyStimulus(1'b0, 3'b010, 32'h20, 32'd0, d);
      checkOutput("lw_20", d, 32'hDEADBEEF);

      // Rejected accesses and address boundaries.
      applyStimulus(1'b0, 3'b001, 32'h11, 32'd0, d);
      applyStimulus(1'b1, 3'b010, 32'h22, 32'h12345678, d);
      applyStimulus(1'b0, 3'b010, 32'h800, 32'd0, d);
      applyStimulus(1'b0, 3'b011, 32'h10, 32'd0, d);
      applyStimulus(1'b1, 3'b011, 32'h10, 32'h1, d);
      applyStimulus(1'b1, 3'b100, 32'h10, 32'h1, d);
      applyStimulus(1'b0, 3'b110, 32'h10, 32'd0, d);
      applyStimulus(1'b0, 3'b000, 32'h80000010, 32'd0, d);
      applyStimulus(1'b1, 3'b000, 32'h7FF, 32'h000000C3, d);
      applyStimulus(1'b0, 3'b100, 32'h7FF, 32'd0, d);
      checkOutput("lbu_7ff", d, 32'h000000C3);
      applyStimulus(1'b0, 3'b010, 32'h7FC, 32'd0, d);
      applyStimulus(1'b0, 3'b000, 32'h800, 32'd0, d);

      // Reset asserted while the SW sits in its write cycle.
      @(negedge clk);
      req_valid_i = 1'b1;
      req_we_i = 1'b1;
      req_funct3_i = 3'b010;
      req_addr_i = 32'h30;
      req_wdata_i = 32'hCAFEF00D;
      @(negedge clk);
      req_valid_i = 1'b0;
      checkOutput("abort_we_before", 32'(mem_we_o), 32'd1);
      rst_i = 1'b1;
      #1;
      checkOutput("abort_we_dropped", 32'(mem_we_o), 32'd0);
      checkOutput("abort_rsp_valid", 32'(rsp_valid_o), 32'd0);
      checkOutput("abort_ready", 32'(req_ready_o), 32'd1);
      checkOutput("abort_addr", 32'(mem_addr_o), 32'd0);
      checkOutput("abort_wdata", mem_wdata_o, 32'd0);
      @(negedge clk);
      rst_i = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checkOutput("abort_no_rsp", 32'(rsp_valid_o), 32'd0);
      end
      checkOutput("abort_word_30", tbMem[12], refWord(32'h30));
      checkOutput("abort_ready_after", 32'(req_ready_o), 32'd1);

      // Requester holds valid with a fresh random load every cycle.
      nextAccept = 0;
      for (int k = 0; k < 66; k++) begin
         @(negedge clk);
         checkOutput("hold_ready", 32'(req_ready_o), (k >= nextAccept) ? 32'd1 : 32'd0);
         expRsp = (expQ.size() > 0) && (expQ[0].cyc == k);
         checkOutput("hold_rsp_valid", 32'(rsp_valid_o), 32'(expRsp));
         if (expRsp) begin
            checkOutput("hold_rdata", rsp_rdata_o, expQ[0].data);
            checkOutput("hold_err", 32'(rsp_err_o), 32'(expQ[0].err));
            void'(expQ.pop_front());
         end
         if (k < 60) begin
            hF3 = 3'($urandom_range(0, 7));
            hAddr = 32'($urandom_range(0, DEPTH + 16));
            req_valid_i = 1'b1;
            req_we_i = 1'b0;
            req_funct3_i = hF3;
            req_addr_i = hAddr;
            req_wdata_i = $urandom;
            if (k >= nextAccept) begin
               hErr = modelErr(1'b0, hF3, hAddr);
               hLat = modelLatency(1'b0, hF3, hErr);
               expQ.push_back('{cyc: k + hLat, data: hErr ? 32'd0 : modelLoad(hF3, hAddr), err: hErr});
               nextAccept = k + hLat + 1;
            end
         end else begin
            req_valid_i = 1'b0;
         end
      end
      checkOutput("hold_drained", 32'(expQ.size()), 32'd0);

      // Randomized sequential mix of loads and stores.
      for (int n = 0; n < 120; n++) begin
         rWe = 1'($urandom_range(0, 1));
         rF3 = 3'($urandom_range(0, 7));
         rAddr = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, DEPTH - 1));
         if ($urandom_range(0, 3) != 0) begin
            if (rF3[1:0] == 2'b01) rAddr[0] = 1'b0;
            if (rF3[1:0] == 2'b10) rAddr[1:0] = 2'b00;
         end
         applyStimulus(rWe, rF3, rAddr, $urandom, d);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/lsu_mem_ctrl.md
# lsu_mem_ctrl

Load/store controller sitting between the RV32I execute stage and the word-wide data memory (asynchronous read, write on rising clock edge, full-word writes only). It accepts one byte/half/word load or store at a time, performs byte-lane extraction with sign/zero extension for loads, and read-modify-write sequencing for sub-word stores. It flags misaligned, out-of-range or illegal-funct3 accesses without touching memory.

## Interface
- DEPTH, 2048, data memory size in bytes; must equal the attached memory's DEPTH
- clk  input  1  clock; all state updates on rising edge
- rst_i  input  1  asynchronous, active-high reset
- req_valid_i  input  1  request present
- req_ready_o  output  1  controller idle, can accept
- req_we_i  input  1  1 = store, 0 = load
- req_funct3_i  input  3  RV32I funct3: loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores 000 SB, 001 SH, 010 SW
- req_addr_i  input  32  byte address
- req_wdata_i  input  32  store data (SB uses [7:0], SH uses [15:0])
- rsp_valid_o  output  1  one-cycle response pulse
- rsp_rdata_o  output  32  load result; 0 for stores and errors
- rsp_err_o  output  1  access rejected; qualified by rsp_valid_o
- mem_addr_o  output  $clog2(DEPTH)  byte address to memory
- mem_wdata_o  output  32  full word to write
- mem_we_o  output  1  memory write enable
- mem_rdata_i  input  32  memory read data, combinational from mem_addr_o

## Operation
- States: IDLE, LOAD, RMW_RD, WRITE, RESP.
- IDLE: req_ready_o=1. On req_valid_i at rising edge, latch we/funct3/addr/wdata and classify:
  - error if funct3 illegal for direction (load: 011, 110, 111; store: anything other than 000/001/010), half with addr[0]=1, word with addr[1:0]≠0, or addr ≥ DEPTH → RESP, err=1.
  - load → LOAD; SW → WRITE (mem_wdata_o=req_wdata_i); SB/SH → RMW_RD.
- LOAD: mem_addr_o=latched addr; on edge, select lane addr[1:0] (byte) or addr[1] (half) from mem_rdata_i, little-endian (byte k = bits [8k+7:8k]); LB/LH sign-extend, LBU/LHU zero-extend, LW pass-through; register into rsp_rdata_o → RESP.
- RMW_RD: on edge, merge store byte/half into mem_rdata_i at the addressed lane, other lanes unchanged, register as mem_wdata_o → WRITE.
- WRITE: mem_we_o=1 for exactly this cycle; memory commits on the exiting edge → RESP.
- RESP: rsp_valid_o=1 one cycle, rsp_err_o per classification, rsp_rdata_o=0 unless successful load → IDLE.
- mem_addr_o holds the last latched address outside active states; mem_we_o is 0 in every state except WRITE.
- Requests arriving while req_ready_o=0 are ignored; requester must hold them.

## Timing
- Cycle 0 = accept edge. rsp_valid_o high in cycle: error 1, load 2, SW 2, SB/SH 3.
- Back-to-back: next request accepted in the cycle after RESP (req_ready_o=1 again).
- Store data visible to a following load: yes, write committed before RESP.
- Reset values: state IDLE, req_ready_o=1, rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0.
- Reset mid-operation: outputs go to reset values immediately; a WRITE interrupted before its edge performs no write; no response is issued for the aborted request.
- Address width rule: mem_addr_o = req_addr_i[$clog2(DEPTH)-1:0]; range check uses the full 32-bit address.

## Test plan
- Memory word @0x10 = 0x8899AABB; LB 0x11 → rdata 0xFFFFFFAA; LBU 0x13 → 0x00000088; LH 0x12 → 0xFFFF8899; LW 0x10 → 0x8899AABB; each rsp_valid in cycle 2.
- SB 0x12 data 0x55 on 0x8899AABB → exactly one mem_we_o pulse in cycle 2, word becomes 0x8855AABB, rsp in cycle 3; SH 0x10 data 0x1234 → 0x88551234.
- SW 0x20 0xDEADBEEF then LW 0x20 back-to-back → 0xDEADBEEF, no error.
- LH 0x11, SW 0x22, LW 0x800 (DEPTH=2048), load funct3 011 → rsp_err_o=1 in cycle 1, rdata 0, mem_we_o never asserted.
- Assert rst_i during WRITE of SW 0x30 0xCAFEF00D → mem_we_o drops immediately, word @0x30 unchanged, no rsp_valid_o, req_ready_o=1 after release.
- Hold req_valid_i continuously with changing addr while busy → only requests present at IDLE edges are accepted, one rsp per accept.
